// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic pipeline stages of the core.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pipe_pkg;

  // Occupancy states of one elastic stage.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } pipe_state_e;

  // NOP instruction encoding; doubles as the bubble payload.
  localparam logic [31:0] PIPE_NOP = 32'h0000_003F;

  // Basic field widths used to size the per-stage payload vectors.
  localparam int PC_W     = 32;
  localparam int INSTR_W  = 32;
  localparam int XLEN     = 32;
  localparam int REG_IDX_W = 5;
  localparam int CTRL_W   = 8;

  // Packed payload widths for each stage boundary.
  localparam int IFID_W  = PC_W + INSTR_W;
  localparam int IDEX_W  = PC_W + 2 * XLEN + REG_IDX_W + CTRL_W;
  localparam int EXMEM_W = 2 * XLEN + REG_IDX_W + CTRL_W;
  localparam int MEMWB_W = XLEN + REG_IDX_W + CTRL_W;

  // Number of valid entries held in a given state.
  function automatic logic [1:0] state_occ(input pipe_state_e s);
    case (s)
      ONE:     return 2'd1;
      FULL:    return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
// Latency: count reflects en one cycle after the edge that samples it.
// Backpressure: none; holds at all-ones once saturated.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  // Next count: step by one unless already at the maximum.
  always_comb begin
    cnt_d = cnt_q;
    if (en && (cnt_q != {WIDTH{1'b1}})) begin
      cnt_d = cnt_q + WIDTH'(1);
    end
  end

  // Count register; clear wins over counting.
  always_ff @(posedge clk) begin
    if (clr) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count = cnt_q;

endmodule

// File: rtl/pipe_skid_stage.sv
// Elastic pipeline register with a two-entry skid buffer, flush and stall counter.
// Latency: 1 cycle from accept to out_valid; sustains 1 payload/cycle.
// Backpressure: in_ready comes only from registered state; one extra payload is absorbed into skid.
module pipe_skid_stage
  import pipe_pkg::*;
#(
  parameter int               WIDTH  = 32,
  parameter logic [WIDTH-1:0] BUBBLE = WIDTH'(PIPE_NOP),
  parameter int               CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  input  logic             flush,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] stall_cnt
);

  pipe_state_e      state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             accept;
  logic             consume;

  // Handshake outputs are decoded from registered state only (rst just gates in_ready).
  assign in_ready  = (state_q != FULL) & ~rst;
  assign out_valid = (state_q != EMPTY);
  assign out_data  = main_q;
  assign occupancy = state_occ(state_q);

  assign accept  = in_valid & in_ready;
  assign consume = out_valid & out_ready;

  // Next state and entry contents; flush overrides every transition.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          state_d = ONE;
          main_d  = in_data;
        end
      end
      ONE: begin
        if (accept && !consume) begin
          state_d = FULL;
          skid_d  = in_data;
        end else if (accept && consume) begin
          main_d = in_data;
        end else if (consume) begin
          state_d = EMPTY;
          main_d  = BUBBLE;
        end
      end
      FULL: begin
        if (consume) begin
          state_d = ONE;
          main_d  = skid_q;
          skid_d  = BUBBLE;
        end
      end
      default: begin
        state_d = EMPTY;
        main_d  = BUBBLE;
        skid_d  = BUBBLE;
      end
    endcase
    if (flush) begin
      state_d = EMPTY;
      main_d  = BUBBLE;
      skid_d  = BUBBLE;
    end
  end

  // State and entry registers; reset empties the stage and loads bubbles.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      main_q  <= BUBBLE;
      skid_q  <= BUBBLE;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  // Stall cycles are counted regardless of flush; only reset clears them.
  sat_counter #(
    .WIDTH(CNT_W)
  ) u_stall_cnt (
    .clk  (clk),
    .clr  (rst),
    .en   (out_valid & ~out_ready),
    .count(stall_cnt)
  );

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Bench for pipe_skid_stage: queue-based reference model plus directed and random stimulus.
// Latency: checks every cycle at the falling edge.
// Backpressure: random out_ready and flush exercise skid and bubble paths.
module tb_pipe_skid_stage;

  localparam logic [31:0] BUB = 32'h0000_003F;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_data;
  logic        out_ready;
  logic        flush;

  logic        in_ready, out_valid;
  logic [31:0] out_data;
  logic [1:0]  occupancy;
  logic [15:0] stall_cnt;

  logic        in_ready4, out_valid4;
  logic [31:0] out_data4;
  logic [1:0]  occupancy4;
  logic [3:0]  stall_cnt4;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: payload queue plus an unbounded stall count.
  logic [31:0] mq[$];
  int          mcnt = 0;
  bit          model_ok = 0;

  always #5 clk = ~clk;

  pipe_skid_stage u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .flush(flush),
    .occupancy(occupancy), .stall_cnt(stall_cnt)
  );

  pipe_skid_stage #(.CNT_W(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4), .in_data(in_data),
    .out_valid(out_valid4), .out_ready(out_ready), .out_data(out_data4), .flush(flush),
    .occupancy(occupancy4), .stall_cnt(stall_cnt4)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int sat(input int c, input int maxv);
    return (c > maxv) ? maxv : c;
  endfunction

  // Model update on each rising edge from the inputs held stable across it.
  always @(posedge clk) begin
    bit acc, con;
    if (rst) begin
      mq.delete();
      mcnt = 0;
      model_ok = 1;
    end else if (model_ok) begin
      acc = in_valid && (mq.size() < 2);
      con = (mq.size() > 0) && out_ready;
      if ((mq.size() > 0) && !out_ready) mcnt++;
      if (flush) begin
        mq.delete();
      end else begin
        if (con) void'(mq.pop_front());
        if (acc) mq.push_back(in_data);
      end
    end
  end

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (model_ok) begin
      logic [31:0] e_dat;
      logic        e_vld, e_rdy;
      e_vld = (mq.size() > 0);
      e_dat = e_vld ? mq[0] : BUB;
      e_rdy = (mq.size() < 2) && !rst;
      chk("in_ready",   64'(in_ready),   64'(e_rdy));
      chk("out_valid",  64'(out_valid),  64'(e_vld));
      chk("out_data",   64'(out_data),   64'(e_dat));
      chk("occupancy",  64'(occupancy),  64'(mq.size()));
      chk("stall_cnt",  64'(stall_cnt),  64'(sat(mcnt, 65535)));
      chk("in_ready4",  64'(in_ready4),  64'(e_rdy));
      chk("out_valid4", 64'(out_valid4), 64'(e_vld));
      chk("out_data4",  64'(out_data4),  64'(e_dat));
      chk("occupancy4", 64'(occupancy4), 64'(mq.size()));
      chk("stall_cnt4", 64'(stall_cnt4), 64'(sat(mcnt, 15)));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b1; in_data = 32'h55; out_ready = 1'b0; flush = 1'b0;

    // Reset held for two edges with in_valid asserted.
    tick(); tick();
    chk("rst_in_ready",  64'(in_ready),  64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data",  64'(out_data),  64'h3F);
    chk("rst_occ",       64'(occupancy), 64'd0);
    chk("rst_stall",     64'(stall_cnt), 64'd0);
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    #1;
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);

    // Streaming 1..16 with downstream always ready.
    for (int i = 1; i <= 16; i++) begin
      in_valid = 1'b1; in_data = 32'(i);
      tick();
      chk("stream_data", 64'(out_data),  64'(i));
      chk("stream_occ",  64'(occupancy), 64'd1);
    end
    in_valid = 1'b0;
    tick();
    chk("stream_drained", 64'(out_valid), 64'd0);

    // Backpressure: A and B absorbed, C held off.
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'hA;
    tick();
    in_data = 32'hB;
    tick();
    chk("bp_occ2",  64'(occupancy), 64'd2);
    chk("bp_rdy0",  64'(in_ready),  64'd0);
    in_data = 32'hC;
    tick(); tick();
    chk("bp_hold_data", 64'(out_data),  64'hA);
    chk("bp_stall",     64'(stall_cnt), 64'd3);
    out_ready = 1'b1;
    tick();
    chk("bp_second", 64'(out_data), 64'hB);
    tick();
    chk("bp_third", 64'(out_data), 64'hC);
    in_valid = 1'b0;
    tick();
    chk("bp_empty", 64'(out_valid), 64'd0);

    // Flush from FULL with a simultaneous offer of D.
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'hA;
    tick();
    in_data = 32'hB;
    tick();
    chk("fl_occ2", 64'(occupancy), 64'd2);
    flush = 1'b1; in_data = 32'hD;
    tick();
    chk("fl_out_valid", 64'(out_valid), 64'd0);
    chk("fl_out_data",  64'(out_data),  64'h3F);
    chk("fl_occ",       64'(occupancy), 64'd0);
    chk("fl_in_ready",  64'(in_ready),  64'd1);
    chk("fl_stall",     64'(stall_cnt), 64'd5);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    tick(); tick();
    chk("fl_no_d", 64'(out_valid), 64'd0);

    // Saturation of the 4-bit counter.
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h77;
    tick();
    in_valid = 1'b0;
    repeat (20) tick();
    chk("sat_stall4",  64'(stall_cnt4), 64'd15);
    chk("sat_stall16", 64'(stall_cnt),  64'd25);
    flush = 1'b1;
    tick();
    chk("sat_flush4",  64'(stall_cnt4), 64'd15);
    chk("sat_flush16", 64'(stall_cnt),  64'd26);
    flush = 1'b0; rst = 1'b1;
    tick();
    chk("sat_rst4",  64'(stall_cnt4), 64'd0);
    chk("sat_rst16", 64'(stall_cnt),  64'd0);
    rst = 1'b0;

    // Random traffic checked by the every-cycle comparison.
    for (int c = 0; c < 4000; c++) begin
      in_valid  = ($urandom_range(0, 1) == 0);
      in_data   = $urandom;
      out_ready = ($urandom_range(0, 4) < 3);
      flush     = ($urandom_range(0, 31) == 0);
      rst       = ($urandom_range(0, 499) == 0);
      tick();
    end
    in_valid = 1'b0; flush = 1'b0; rst = 1'b0; out_ready = 1'b1;
    repeat (4) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
